apb_gpio_arbiter: RTL and testbench

Two-requester APB master that shares the single APB slave port of the GPIO block (apb_top) between independent agents. Example agents are a CPU-side bus bridge and an autonomous config/poll sequencer. The block arbitrates round-robin, drives the APB SETUP/ACCESS protocol and waits for PREADY. It returns read data and a completion/error pulse to the winning requester, and aborts hung transfers with a timeout.

---
 rtl/apb_gpio_arbiter_if.sv | 42 ++++
 rtl/apb_gpio_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_apb_gpio_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_arbiter_if.sv
// Bundle of the requester-side handshakes and the APB master bus of apb_gpio_arbiter.
// The "master" modport is the arbiter's view; the "slave" modport is the requester/slave environment's view.
interface apb_gpio_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              write0;
    logic              write1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              grant;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  req0, req1, addr0, addr1, write0, write1, wdata0, wdata1,
        input  PRDATA, PREADY,
        output ack0, ack1, err, rdata, grant, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req0, req1, addr0, addr1, write0, write1, wdata0, wdata1,
        output PRDATA, PREADY,
        input  ack0, ack1, err, rdata, grant, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_gpio_arbiter.sv
// Round-robin arbiter that lets two requesters share one APB slave port, with a
// SETUP/ACCESS master sequencer, registered completion pulses and a hung-transfer timeout.
module apb_gpio_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    apb_gpio_arbiter_if.master     bus
);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [1:0]        r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_grant;
    logic              r_busy;
    logic              r_rr_last;
    logic [7:0]        r_cnt;

    logic              w_psel_next;
    logic              w_penable_next;
    logic              w_pwrite_next;
    logic [ADDR_W-1:0] w_paddr_next;
    logic [DATA_W-1:0] w_pwdata_next;
    logic [1:0]        w_ack_next;
    logic              w_err_next;
    logic [DATA_W-1:0] w_rdata_next;
    logic              w_grant_next;
    logic              w_busy_next;
    logic              w_rr_last_next;
    logic [7:0]        w_cnt_next;
    logic [7:0]        w_cnt_inc;

    // Requester ports gathered into indexable arrays so selection is by grant id.
    logic [1:0]        w_req;
    logic [1:0]        w_write;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic [1:0]        w_elig;
    logic              w_pick_valid;
    logic              w_pick;

    assign w_req      = {bus.req1, bus.req0};
    assign w_write    = {bus.write1, bus.write0};
    assign w_addr[0]  = bus.addr0;
    assign w_addr[1]  = bus.addr1;
    assign w_wdata[0] = bus.wdata0;
    assign w_wdata[1] = bus.wdata1;

    // A requester still seeing its ack is holding a stale req; it must not be re-granted.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign w_elig[gi] = w_req[gi] & ~r_ack[gi];
        end
    endgenerate

    assign w_pick_valid = |w_elig;
    assign w_pick       = (w_elig == 2'b11) ? ~r_rr_last : w_elig[1];
    assign w_cnt_inc    = r_cnt + 8'd1;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_psel_next    = r_psel;
        w_penable_next = r_penable;
        w_pwrite_next  = r_pwrite;
        w_paddr_next   = r_paddr;
        w_pwdata_next  = r_pwdata;
        w_ack_next     = 2'b00;
        w_err_next     = 1'b0;
        w_rdata_next   = r_rdata;
        w_grant_next   = r_grant;
        w_busy_next    = r_busy;
        w_rr_last_next = r_rr_last;
        w_cnt_next     = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_next   = w_pick;
                    w_rr_last_next = w_pick;
                    w_paddr_next   = w_addr[w_pick];
                    w_pwrite_next  = w_write[w_pick];
                    w_pwdata_next  = w_wdata[w_pick];
                    w_psel_next    = 1'b1;
                    w_penable_next = 1'b0;
                    w_busy_next    = 1'b1;
                    w_state_next   = S_SETUP;
                end
            end
            S_SETUP: begin
                w_penable_next = 1'b1;
                w_cnt_next     = 8'd0;
                w_state_next   = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    if (!r_pwrite) begin
                        w_rdata_next = bus.PRDATA;
                    end
                    w_ack_next[r_grant] = 1'b1;
                    w_err_next          = 1'b0;
                    w_psel_next         = 1'b0;
                    w_penable_next      = 1'b0;
                    w_busy_next         = 1'b0;
                    w_state_next        = S_IDLE;
                end else if (w_cnt_inc == TO_LIMIT) begin
                    // Slave never answered: abort and report the failure to the owner.
                    w_ack_next[r_grant] = 1'b1;
                    w_err_next          = 1'b1;
                    w_rdata_next        = '0;
                    w_psel_next         = 1'b0;
                    w_penable_next      = 1'b0;
                    w_busy_next         = 1'b0;
                    w_state_next        = S_IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_psel_next    = 1'b0;
                w_penable_next = 1'b0;
                w_busy_next    = 1'b0;
                w_state_next   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_ack     <= 2'b00;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_grant   <= 1'b0;
            r_busy    <= 1'b0;
            r_rr_last <= 1'b1;
            r_cnt     <= 8'd0;
        end else begin
            r_psel    <= w_psel_next;
            r_penable <= w_penable_next;
            r_pwrite  <= w_pwrite_next;
            r_paddr   <= w_paddr_next;
            r_pwdata  <= w_pwdata_next;
            r_ack     <= w_ack_next;
            r_err     <= w_err_next;
            r_rdata   <= w_rdata_next;
            r_grant   <= w_grant_next;
            r_busy    <= w_busy_next;
            r_rr_last <= w_rr_last_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign bus.PSEL    = r_psel;
    assign bus.PENABLE = r_penable;
    assign bus.PWRITE  = r_pwrite;
    assign bus.PADDR   = r_paddr;
    assign bus.PWDATA  = r_pwdata;
    assign bus.ack0    = r_ack[0];
    assign bus.ack1    = r_ack[1];
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Directed bench for apb_gpio_arbiter: a small register-file slave with a programmable
// wait/hang, a transaction-age reference model checked every cycle, and literal spot checks.
module tb_apb_gpio_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_gpio_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_gpio_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(clk), .PRESET(rst), .bus(bus)
    );

    // Requester drive
    logic        t_req   [2];
    logic        t_write [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    assign bus.req0   = t_req[0];
    assign bus.req1   = t_req[1];
    assign bus.write0 = t_write[0];
    assign bus.write1 = t_write[1];
    assign bus.addr0  = t_addr[0];
    assign bus.addr1  = t_addr[1];
    assign bus.wdata0 = t_wdata[0];
    assign bus.wdata1 = t_wdata[1];

    // GPIO-like slave: 0x00 DATA, 0x04 OE, 0x08 IN (read-only pads), 0x0C spare
    logic [31:0] s_mem [4];
    logic        slave_en;
    int          slave_wait;
    int          s_cnt = 0;
    assign bus.PRDATA = s_mem[bus.PADDR[3:2]];
    assign bus.PREADY = slave_en && (s_cnt >= slave_wait);
    always @(posedge clk) begin
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && bus.PADDR[3:2] != 2'd2)
            s_mem[bus.PADDR[3:2]] <= bus.PWDATA;
        s_cnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? s_cnt + 1 : 0;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transfer in flight at most, tracked by its age since grant.
    bit          m_inflight;
    int          m_age;
    bit          m_id;
    bit          m_rr_last;
    logic [31:0] m_mem [4];
    logic [31:0] e_paddr, e_pwdata, e_rdata;
    logic        e_pwrite, e_grant, e_err;
    logic [1:0]  e_ack;
    logic [1:0]  m_ack_prev;
    bit          m_el0, m_el1, m_ready;
    int          m_waits;

    always @(posedge clk) begin
        if (rst) begin
            m_inflight = 0; m_age = 0; m_id = 0; m_rr_last = 1;
            e_paddr = 0; e_pwdata = 0; e_rdata = 0; e_pwrite = 0;
            e_grant = 0; e_err = 0; e_ack = 0;
        end else begin
            m_ack_prev = e_ack;
            e_ack = 0;
            e_err = 0;
            if (!m_inflight) begin
                m_el0 = t_req[0] && !m_ack_prev[0];
                m_el1 = t_req[1] && !m_ack_prev[1];
                if (m_el0 || m_el1) begin
                    m_id       = (m_el0 && m_el1) ? !m_rr_last : m_el1;
                    m_rr_last  = m_id;
                    e_grant    = m_id;
                    e_paddr    = t_addr[m_id];
                    e_pwrite   = t_write[m_id];
                    e_pwdata   = t_wdata[m_id];
                    m_inflight = 1;
                    m_age      = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else begin
                m_waits = m_age - 1;
                m_ready = slave_en && (m_waits >= slave_wait);
                if (m_ready) begin
                    if (e_pwrite) begin
                        if (e_paddr[3:2] != 2'd2) m_mem[e_paddr[3:2]] = e_pwdata;
                    end else begin
                        e_rdata = m_mem[e_paddr[3:2]];
                    end
                    e_ack[m_id] = 1'b1;
                    m_inflight  = 0;
                end else if (m_waits + 1 == TO) begin
                    e_ack[m_id] = 1'b1;
                    e_err       = 1'b1;
                    e_rdata     = 0;
                    m_inflight  = 0;
                end else begin
                    m_age = m_age + 1;
                end
            end
        end
    end

    // Per-cycle compare plus one log line per completed transaction
    always @(negedge clk) begin
        if (chk_en) begin
            check("PSEL",    {63'd0, bus.PSEL},    {63'd0, m_inflight});
            check("PENABLE", {63'd0, bus.PENABLE}, {63'd0, m_inflight && m_age >= 1});
            check("busy",    {63'd0, bus.busy},    {63'd0, m_inflight});
            check("PWRITE",  {63'd0, bus.PWRITE},  {63'd0, e_pwrite});
            check("PADDR",   {32'd0, bus.PADDR},   {32'd0, e_paddr});
            check("PWDATA",  {32'd0, bus.PWDATA},  {32'd0, e_pwdata});
            check("ack",     {62'd0, bus.ack1, bus.ack0}, {62'd0, e_ack});
            check("err",     {63'd0, bus.err},     {63'd0, e_err});
            check("rdata",   {32'd0, bus.rdata},   {32'd0, e_rdata});
            check("grant",   {63'd0, bus.grant},   {63'd0, e_grant});
            if (bus.ack0 || bus.ack1)
                $display("TXN cyc=%0d id=%0d write=%0d addr=%h err=%0d rdata=%h",
                         cyc, bus.ack1, bus.PWRITE, bus.PADDR, bus.err, bus.rdata);
        end
    end

    // Single request from one requester; reports phase timing relative to the request.
    task automatic single(input int id, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output logic err_o, output logic [31:0] rd_o,
                          output int psel_at, output int pen_at, output int ack_at);
        bit ok;
        @(negedge clk);
        t_req[id] = 1; t_write[id] = wr; t_addr[id] = addr; t_wdata[id] = wd;
        psel_at = -1; pen_at = -1; ack_at = -1; ok = 0; err_o = 0; rd_o = 0;
        for (int n = 1; n <= 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.PSEL && psel_at < 0) psel_at = n;
            if (bus.PENABLE && pen_at < 0) pen_at = n;
            if ((id == 0) ? bus.ack0 : bus.ack1) begin
                ack_at = n; err_o = bus.err; rd_o = bus.rdata; ok = 1;
            end
        end
        t_req[id] = 0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL single_ack_wait actual=none required=ack id=%0d", id);
        end
    endtask

    int          g_n;
    int          g_id [16];
    int          g_at [16];
    logic [31:0] g_rd [16];
    logic        g_err[16];

    // Both requesters hold req until they have received n0 / n1 acks respectively.
    task automatic run_both(input int n0, input int n1);
        int rem0, rem1;
        rem0 = n0; rem1 = n1; g_n = 0;
        t_req[0] = (n0 > 0); t_req[1] = (n1 > 0);
        for (int n = 1; n <= 300 && (rem0 > 0 || rem1 > 0); n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (((k == 0) ? bus.ack0 : bus.ack1) && g_n < 16) begin
                    g_id[g_n] = k; g_at[g_n] = n; g_rd[g_n] = bus.rdata; g_err[g_n] = bus.err;
                    g_n++;
                    if (k == 0) begin rem0--; if (rem0 == 0) t_req[0] = 0; end
                    else        begin rem1--; if (rem1 == 0) t_req[1] = 0; end
                end
            end
        end
        t_req[0] = 0; t_req[1] = 0;
        if (rem0 > 0 || rem1 > 0) begin
            checks++; failures++;
            $display("FAIL run_both_wait actual=%0d,%0d outstanding required=0,0", rem0, rem1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        er;
    int          ps, pe, ak;
    bit          seen;

    initial begin
        for (int k = 0; k < 2; k++) begin
            t_req[k] = 0; t_write[k] = 0; t_addr[k] = 0; t_wdata[k] = 0;
        end
        s_mem[0] = 32'h0;  s_mem[1] = 32'h0;  s_mem[2] = 32'hABFE_FABE; s_mem[3] = 32'h0;
        m_mem[0] = 32'h0;  m_mem[1] = 32'h0;  m_mem[2] = 32'hABFE_FABE; m_mem[3] = 32'h0;
        slave_en = 1; slave_wait = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("rst_PSEL",  {63'd0, bus.PSEL},  64'd0);
        check("rst_busy",  {63'd0, bus.busy},  64'd0);
        check("rst_grant", {63'd0, bus.grant}, 64'd0);
        check("rst_rdata", {32'd0, bus.rdata}, 64'd0);
        rst = 0;

        // Write OE=all ones, then read it back
        single(0, 1'b1, 32'h04, 32'hFFFF_FFFF, er, rd, ps, pe, ak);
        check("t1_psel_at", 64'(ps), 64'd1);
        check("t1_pen_at",  64'(pe), 64'd2);
        check("t1_ack_at",  64'(ak), 64'd3);
        check("t1_err",     {63'd0, er}, 64'd0);
        single(0, 1'b0, 32'h04, 32'h0, er, rd, ps, pe, ak);
        check("t1_readback", {32'd0, rd}, 64'hFFFF_FFFF);

        // Simultaneous requests straight out of reset
        @(negedge clk); rst = 1;
        @(negedge clk); @(negedge clk); rst = 0;
        t_write[0] = 1; t_addr[0] = 32'h00; t_wdata[0] = 32'h1234_5678;
        t_write[1] = 0; t_addr[1] = 32'h04;
        run_both(1, 1);
        check("t2_first",  64'(g_id[0]), 64'd0);
        check("t2_second", 64'(g_id[1]), 64'd1);
        check("t2_gap",    64'(g_at[1] - g_at[0]), 64'd3);
        check("t2_rdata1", {32'd0, g_rd[1]}, 64'hFFFF_FFFF);

        // Continuous contention: strict alternation, 3 cycles per transfer
        t_addr[1] = 32'h00;
        run_both(4, 4);
        for (int i = 0; i < 8; i++) check("t3_grant", 64'(g_id[i]), 64'(i % 2));
        for (int i = 1; i < 8; i++) check("t3_gap", 64'(g_at[i] - g_at[i-1]), 64'd3);

        // Two wait states stretch ACCESS
        slave_wait = 2;
        single(1, 1'b0, 32'h00, 32'h0, er, rd, ps, pe, ak);
        check("tw_ack_at", 64'(ak), 64'd5);
        check("tw_rdata",  {32'd0, rd}, 64'h1234_5678);
        slave_wait = 0;

        // Hung slave: abort after TO cycles in ACCESS, then normal service resumes
        slave_en = 0;
        single(0, 1'b0, 32'h04, 32'h0, er, rd, ps, pe, ak);
        check("t4_to_delay", 64'(ak - pe), 64'd16);
        check("t4_err",      {63'd0, er}, 64'd1);
        check("t4_rdata",    {32'd0, rd}, 64'd0);
        slave_en = 1;
        single(0, 1'b0, 32'h04, 32'h0, er, rd, ps, pe, ak);
        check("t4_after_err", {63'd0, er}, 64'd0);
        check("t4_after_rd",  {32'd0, rd}, 64'hFFFF_FFFF);

        // Reset during ACCESS of a req1 read
        slave_en = 0;
        @(negedge clk);
        t_req[1] = 1; t_write[1] = 0; t_addr[1] = 32'h08;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.PENABLE) seen = 1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL t5_access_wait actual=no_access required=access");
        end
        repeat (2) @(negedge clk);
        rst = 1;
        t_req[0] = 1; t_write[0] = 1; t_addr[0] = 32'h00; t_wdata[0] = 32'hCAFE_0001;
        @(negedge clk);
        check("t5_psel",    {63'd0, bus.PSEL},    64'd0);
        check("t5_penable", {63'd0, bus.PENABLE}, 64'd0);
        check("t5_ack1",    {63'd0, bus.ack1},    64'd0);
        check("t5_busy",    {63'd0, bus.busy},    64'd0);
        @(negedge clk);
        rst = 0; slave_en = 1;
        run_both(1, 1);
        check("t5_first",  64'(g_id[0]), 64'd0);
        check("t5_second", 64'(g_id[1]), 64'd1);
        check("t6_in_rd",  {32'd0, g_rd[1]}, 64'hABFE_FABE);
        check("t6_in_err", {63'd0, g_err[1]}, 64'd0);

        // rdata holds across a write completion
        single(0, 1'b1, 32'h00, 32'h5555_AAAA, er, rd, ps, pe, ak);
        check("t6_hold", {32'd0, bus.rdata}, 64'hABFE_FABE);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
